pipe_stage_skid_reg: RTL

- Parametrised successor to the fixed-field inter-stage pipeline registers.
- One pipeline stage boundary (e.g. ID/EX, EX/MEM) with a valid/ready handshake and a 2-entry skid buffer, so upstream stall is registered rather than combinational.
- Flush inserts a bubble by clearing control bits.
- Data and control payloads are separate, parametrised buses; the CPU packs its fields into them.

---
 rtl/pipe_stage_skid_reg.sv | 79 +++++++
 1 files changed

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage boundary register with a valid/ready handshake and a 2-entry skid buffer.
// in_ready comes straight from a flop, so downstream stall never reaches upstream combinationally.
module pipe_stage_skid_reg #(
    parameter int DATA_W   = 32,
    parameter int CTRL_W   = 16,
    parameter bit CLR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              main_valid, skid_valid;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic              accept, main_free;

    assign accept    = in_valid & ~skid_valid;
    // Main can take a new entry when it is empty or its entry leaves this cycle.
    assign main_free = ~main_valid | out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            if (CLR_DATA) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else if (main_free) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                main_ctrl  <= skid_ctrl;
                skid_valid <= 1'b0;
                skid_ctrl  <= '0;
                if (CLR_DATA) skid_data <= '0;
            end else if (accept) begin
                main_valid <= 1'b1;
                main_data  <= in_data;
                main_ctrl  <= in_ctrl;
            end else begin
                // Drained with no refill: leave a bubble behind.
                main_valid <= 1'b0;
                main_ctrl  <= '0;
                if (CLR_DATA) main_data <= '0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
            skid_ctrl  <= in_ctrl;
        end
    end

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule
